// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: writeback source select encodings.
package wb_regfile_pkg;

  localparam logic [1:0] WbSelAlu  = 2'b00;
  localparam logic [1:0] WbSelMem  = 2'b01;
  localparam logic [1:0] WbSelPc4  = 2'b10;
  localparam logic [1:0] WbSelNone = 2'b11;

  // True when the select code produces a register write.
  function automatic logic wb_sel_writes(input logic [1:0] sel);
    return sel != WbSelNone;
  endfunction

endpackage

// File: rtl/wb_regfile_rf_core.sv
// Register storage array with one write port and two combinational read ports.
// Index 0 is never written and always reads as zero.
module rf_core
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr1,
  input  logic [AddrWidth-1:0] raddr2,
  output logic [DataWidth-1:0] rdata1,
  output logic [DataWidth-1:0] rdata2
);

  localparam int unsigned NumRegs = 1 << AddrWidth;

  logic [DataWidth-1:0] mem_q [NumRegs];
  logic [DataWidth-1:0] mem_d [NumRegs];

  // Next-state of the array: single write, index 0 protected.
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage update; synchronous reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Zero-latency reads; index 0 forced to zero.
  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source mux, write enable, write-first bypass onto the
// decode read ports, and the retired-instruction counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned datawidth = 32,
  parameter int unsigned regindex  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid,
  input  logic [datawidth-1:0] DataMEM,
  input  logic [datawidth-1:0] DataALU,
  input  logic [datawidth-1:0] PCplus4,
  input  logic [regindex-1:0]  regdindex,
  input  logic [1:0]           WBsel,
  input  logic [regindex-1:0]  rs1index,
  input  logic [regindex-1:0]  rs2index,
  output logic [datawidth-1:0] rs1data,
  output logic [datawidth-1:0] rs2data,
  output logic [datawidth-1:0] wbdata,
  output logic                 wbwen,
  output logic [63:0]          instret
);

  logic [datawidth-1:0] core_rdata1;
  logic [datawidth-1:0] core_rdata2;
  logic                 retire;
  logic [63:0]          instret_q;
  logic [63:0]          instret_d;

  // Writeback source select and commit qualification.
  always_comb begin
    case (WBsel)
      WbSelAlu: wbdata = DataALU;
      WbSelMem: wbdata = DataMEM;
      WbSelPc4: wbdata = PCplus4;
      default:  wbdata = '0;
    endcase
    retire = en & valid & ~rst;
    wbwen  = retire & wb_sel_writes(WBsel) & (regdindex != '0);
  end

  rf_core #(
    .DataWidth(datawidth),
    .AddrWidth(regindex)
  ) u_rf_core (
    .clk    (clk),
    .rst    (rst),
    .we     (wbwen),
    .waddr  (regdindex),
    .wdata  (wbdata),
    .raddr1 (rs1index),
    .raddr2 (rs2index),
    .rdata1 (core_rdata1),
    .rdata2 (core_rdata2)
  );

  // Write-first bypass; wbwen already excludes index 0.
  always_comb begin
    rs1data = (wbwen && (rs1index == regdindex)) ? wbdata : core_rdata1;
    rs2data = (wbwen && (rs2index == regdindex)) ? wbdata : core_rdata2;
  end

  // Retire counter next state; wraps naturally at 2^64.
  always_comb begin
    instret_d = retire ? instret_q + 64'd1 : instret_q;
  end

  // Retire counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised plus directed bench for wb_regfile with a queue-based scoreboard.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] DataMEM = '0;
  logic [31:0] DataALU = '0;
  logic [31:0] PCplus4 = '0;
  logic [4:0]  regdindex = '0;
  logic [1:0]  WBsel = '0;
  logic [4:0]  rs1index = '0;
  logic [4:0]  rs2index = '0;
  logic [31:0] rs1data;
  logic [31:0] rs2data;
  logic [31:0] wbdata;
  logic        wbwen;
  logic [63:0] instret;

  always #5 clk = ~clk;

  wb_regfile #(
    .datawidth(32),
    .regindex (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid     (valid),
    .DataMEM   (DataMEM),
    .DataALU   (DataALU),
    .PCplus4   (PCplus4),
    .regdindex (regdindex),
    .WBsel     (WBsel),
    .rs1index  (rs1index),
    .rs2index  (rs2index),
    .rs1data   (rs1data),
    .rs2data   (rs2data),
    .wbdata    (wbdata),
    .wbwen     (wbwen),
    .instret   (instret)
  );

  typedef struct {
    int          id;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wb;
    logic        wen;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          step_id = 0;

  // Reference model: architectural register contents and retire count.
  logic [31:0] mdl_reg [32];
  logic [63:0] mdl_cnt;

  task automatic check(input int id, input string what, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, what, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.id, "rs1data", 64'(rs1data), 64'(e.rs1));
      check(e.id, "rs2data", 64'(rs2data), 64'(e.rs2));
      check(e.id, "wbdata",  64'(wbdata),  64'(e.wb));
      check(e.id, "wbwen",   64'(wbwen),   64'(e.wen));
      check(e.id, "instret", instret,      e.cnt);
    end
  end

  // Drive one cycle of inputs, queue the expected response, advance the model.
  task automatic step(input bit r, input bit e, input bit v, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                      input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    exp_t        x;
    logic [31:0] sel_val;
    bit          writes;
    @(posedge clk);
    #1;
    rst = r; en = e; valid = v; WBsel = s;
    DataALU = a; DataMEM = m; PCplus4 = p;
    regdindex = rd; rs1index = r1; rs2index = r2;
    step_id++;
    sel_val = (s == 2'd0) ? a : (s == 2'd1) ? m : (s == 2'd2) ? p : 32'd0;
    writes  = e && v && !r && (s != 2'd3) && (rd != 5'd0);
    x.id  = step_id;
    x.wb  = sel_val;
    x.wen = writes;
    x.rs1 = (writes && r1 == rd) ? sel_val : mdl_reg[r1];
    x.rs2 = (writes && r2 == rd) ? sel_val : mdl_reg[r2];
    x.cnt = mdl_cnt;
    sb_q.push_back(x);
    if (r) begin
      foreach (mdl_reg[i]) mdl_reg[i] = '0;
      mdl_cnt = '0;
    end else begin
      if (e && v) mdl_cnt = mdl_cnt + 64'd1;
      if (writes) mdl_reg[rd] = sel_val;
    end
  endtask

  task automatic rnd_step();
    bit          r;
    bit          e;
    bit          v;
    logic [4:0]  rd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    r  = ($urandom_range(0, 39) == 0);
    e  = ($urandom_range(0, 9) != 0);
    v  = ($urandom_range(0, 4) != 0);
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
    r2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
    step(r, e, v, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, rd, r1, r2);
  endtask

  initial begin
    int waited;
    foreach (mdl_reg[i]) mdl_reg[i] = '0;
    mdl_cnt = '0;
    // Bring the DUT out of its unknown power-up state before checking.
    repeat (2) @(posedge clk);

    // Reset, then read index 5.
    step(1, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd5, 5'd5);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd5, 5'd0);

    // Each writeback source stored and read back next cycle.
    step(0, 1, 1, 2'd0, 32'h0000_1234, $urandom, $urandom, 5'd3, 5'd0, 5'd0);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd3, 5'd1);
    step(0, 1, 1, 2'd1, $urandom, 32'hDEAD_BEEF, $urandom, 5'd4, 5'd0, 5'd0);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd4, 5'd3);
    step(0, 1, 1, 2'd2, $urandom, $urandom, 32'h0000_0104, 5'd5, 5'd0, 5'd0);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd5, 5'd4);

    // Same-cycle bypass on both read ports.
    step(0, 1, 1, 2'd0, 32'hCAFE_0001, $urandom, $urandom, 5'd7, 5'd7, 5'd7);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd7, 5'd7);

    // Suppressed writes: index 0, WBsel none, bubble.
    step(0, 1, 1, 2'd0, 32'hFFFF_FFFF, $urandom, $urandom, 5'd0, 5'd0, 5'd0);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd0, 5'd0);
    step(0, 1, 1, 2'd3, $urandom, $urandom, $urandom, 5'd3, 5'd3, 5'd3);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd3, 5'd0);
    step(0, 1, 0, 2'd0, 32'h5555_AAAA, $urandom, $urandom, 5'd4, 5'd4, 5'd4);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd4, 5'd0);

    // Stall, then reset colliding with a valid write.
    step(0, 0, 1, 2'd0, 32'h0909_0909, $urandom, $urandom, 5'd9, 5'd9, 5'd9);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd9, 5'd7);
    step(1, 1, 1, 2'd0, 32'h1010_1010, $urandom, $urandom, 5'd10, 5'd3, 5'd7);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd10, 5'd3);
    step(0, 1, 1, 2'd0, 32'h0000_0BAD, $urandom, $urandom, 5'd11, 5'd0, 5'd0);
    step(0, 1, 0, 2'd0, $urandom, $urandom, $urandom, 5'd0, 5'd11, 5'd7);

    repeat (600) rnd_step();

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
